// File: rtl/sync_mem_pkg.sv
// sync_mem_pkg: FSM state type, read-during-write policy codes and the byte-lane merge
// shared by the write port and the new-data bypass.
package sync_mem_pkg;
  typedef enum logic {INIT, READY} memState;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int MAX_WIDTH = 1024;
  localparam int MAX_LANES = MAX_WIDTH / 8;
  function automatic logic [MAX_WIDTH-1:0] mergeWord(input logic [MAX_WIDTH-1:0] oldWord,
                                                     input logic [MAX_WIDTH-1:0] newWord,
                                                     input logic [MAX_LANES-1:0] mask);
    for (int i = 0; i < MAX_LANES; i++)
      mergeWord[8*i +: 8] = mask[i] ? newWord[8*i +: 8] : oldWord[8*i +: 8];
  endfunction
endpackage

// File: rtl/sync_mem_dp.sv
// sync_mem_dp: simple-dual-port memory with byte masks, 1/2-cycle read latency,
// selectable read-during-write policy and a zeroing sweep after every reset.
module sync_mem_dp
  import sync_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    writeEnable,
  input  logic [ADDR_WIDTH-1:0]   writeAddress,
  input  logic [DATA_WIDTH-1:0]   writeData,
  input  logic [DATA_WIDTH/8-1:0] writeMask,
  input  logic                    readEnable,
  input  logic [ADDR_WIDTH-1:0]   readAddress,
  output logic [DATA_WIDTH-1:0]   readData,
  output logic                    readValid,
  output logic                    initBusy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_WIDTH) begin : gBadWidth
    $error("sync_mem_dp: DATA_WIDTH must be a multiple of 8 and at most %0d", MAX_WIDTH);
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gBadLatency
    $error("sync_mem_dp: READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : gBadRdw
    $error("sync_mem_dp: RDW_MODE must be 0 or 1");
  end
  memState state, nextState;
  logic [ADDR_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mergedWrite, readWord;
  logic readAccept, writeAccept;
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      state   <= INIT;
      counter <= '0;
    end else begin
      state <= nextState;
      if (state == INIT) counter <= counter + 1'b1;
    end
  always_comb begin
    nextState   = (state == INIT && &counter) ? READY : state;
    initBusy    = state == INIT;
    readAccept  = readEnable && state == READY;
    writeAccept = writeEnable && state == READY;
    mergedWrite = DATA_WIDTH'(mergeWord(MAX_WIDTH'(mem[writeAddress]), MAX_WIDTH'(writeData),
                                        MAX_LANES'(writeMask)));
    readWord    = (RDW_MODE == RDW_NEW && writeAccept && writeAddress == readAddress)
                  ? mergedWrite : mem[readAddress];
  end
  // The array itself is never reset; the sweep clears it one word per cycle instead.
  always_ff @(posedge clock)
    if (state == INIT) mem[counter] <= '0;
    else if (writeAccept) mem[writeAddress] <= mergedWrite;
  if (READ_LATENCY == 1) begin : gLat1
    always_ff @(posedge clock or negedge resetN)
      if (!resetN) begin
        readData  <= '0;
        readValid <= 1'b0;
      end else begin
        readValid <= readAccept;
        if (readAccept) readData <= readWord;
      end
  end else begin : gLat2
    logic [DATA_WIDTH-1:0] stage1Data;
    logic stage1Valid;
    always_ff @(posedge clock or negedge resetN)
      if (!resetN) begin
        stage1Data  <= '0;
        stage1Valid <= 1'b0;
        readData    <= '0;
        readValid   <= 1'b0;
      end else begin
        stage1Valid <= readAccept;
        if (readAccept) stage1Data <= readWord;
        readValid <= stage1Valid;
        if (stage1Valid) readData <= stage1Data;
      end
  end
endmodule

// File: tb/tb_sync_mem_dp.sv
// tb_sync_mem_dp: drives two configurations (latency 1/old-data and latency 2/new-data)
// with one stimulus stream and checks both against a word-array reference model.
module tb_sync_mem_dp;
  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic writeEnable = 1'b0, readEnable = 1'b0;
  logic [3:0] writeAddress = '0, readAddress = '0;
  logic [15:0] writeData = '0;
  logic [1:0] writeMask = '0;
  logic [15:0] readDataA, readDataB;
  logic readValidA, readValidB, initBusyA, initBusyB;
  int tests = 0, failed = 0;
  logic [15:0] model [16];
  int initLeft = 16;
  logic expVA = 1'b0, expVB = 1'b0, pendV = 1'b0;
  logic [15:0] expDA = '0, expDB = '0, pendD = '0;

  sync_mem_dp #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_LATENCY(1), .RDW_MODE(0)) dutA (
    .clock(clock), .resetN(resetN), .writeEnable(writeEnable), .writeAddress(writeAddress),
    .writeData(writeData), .writeMask(writeMask), .readEnable(readEnable),
    .readAddress(readAddress), .readData(readDataA), .readValid(readValidA), .initBusy(initBusyA));
  sync_mem_dp #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_LATENCY(2), .RDW_MODE(1)) dutB (
    .clock(clock), .resetN(resetN), .writeEnable(writeEnable), .writeAddress(writeAddress),
    .writeData(writeData), .writeMask(writeMask), .readEnable(readEnable),
    .readAddress(readAddress), .readData(readDataB), .readValid(readValidB), .initBusy(initBusyB));

  always #5 clock = ~clock;

  function automatic logic [15:0] merge(input logic [15:0] oldWord, newWord, input logic [1:0] mask);
    return {mask[1] ? newWord[15:8] : oldWord[15:8], mask[0] ? newWord[7:0] : oldWord[7:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkAll();
    check("validA", 16'(readValidA), 16'(expVA));
    check("dataA", readDataA, expDA);
    check("validB", 16'(readValidB), 16'(expVB));
    check("dataB", readDataB, expDB);
    check("busyA", 16'(initBusyA), 16'(initLeft > 0));
    check("busyB", 16'(initBusyB), 16'(initLeft > 0));
  endtask

  // One clock cycle: drive at negedge, advance the model, compare just after the edge.
  task automatic cycle(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] wm, input logic re, input logic [3:0] ra);
    logic accept;
    logic [15:0] oldWord, newWord, bypass;
    @(negedge clock);
    writeEnable = we; writeAddress = wa; writeData = wd; writeMask = wm;
    readEnable = re; readAddress = ra;
    accept  = re && initLeft == 0;
    oldWord = model[ra];
    newWord = merge(model[wa], wd, wm);
    bypass  = (we && wa == ra) ? newWord : oldWord;
    if (initLeft > 0) begin
      model[16-initLeft] = '0;
      initLeft--;
    end else if (we) model[wa] = newWord;
    @(posedge clock);
    #1;
    expVA = accept;
    if (accept) expDA = oldWord;
    expVB = pendV;
    if (pendV) expDB = pendD;
    pendV = accept;
    if (accept) pendD = bypass;
    checkAll();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 4'd0, 16'd0, 2'd0, 1'b0, 4'd0);
  endtask
  task automatic write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    cycle(1'b1, a, d, m, 1'b0, 4'd0);
  endtask
  task automatic read(input logic [3:0] a);
    cycle(1'b0, 4'd0, 16'd0, 2'd0, 1'b1, a);
  endtask

  task automatic pulseReset();
    #2 resetN = 1'b0;
    #1;
    initLeft = 16; expVA = 0; expVB = 0; pendV = 0; expDA = '0; expDB = '0; pendD = '0;
    checkAll();
    @(posedge clock);
    #1 resetN = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    @(posedge clock);
    #1;
    checkAll();
    resetN = 1'b1;
    repeat (18) read(4'd3);
    write(4'd5, 16'hABCD, 2'b11);
    write(4'd5, 16'h1234, 2'b01);
    read(4'd5);
    check("maskedA", readDataA, 16'hAB34);
    idle(2);
    write(4'd2, 16'h5555, 2'b00);
    read(4'd2);
    check("noMaskA", readDataA, 16'h0000);
    idle(2);
    write(4'd7, 16'h00FF, 2'b11);
    cycle(1'b1, 4'd7, 16'hAA11, 2'b10, 1'b1, 4'd7);
    check("rdwOldA", readDataA, 16'h00FF);
    read(4'd7);
    check("rdwAfterA", readDataA, 16'hAAFF);
    check("rdwNewB", readDataB, 16'hAAFF);
    idle(2);
    write(4'd1, 16'h0101, 2'b11);
    write(4'd2, 16'h0202, 2'b11);
    write(4'd3, 16'h0303, 2'b11);
    read(4'd1); read(4'd2); read(4'd3);
    idle(3);
    check("holdB", readDataB, 16'h0303);
    write(4'd4, 16'hBEEF, 2'b11);
    read(4'd4); read(4'd4);
    pulseReset();
    repeat (16) read(4'd4);
    read(4'd4);
    check("clearedA", readDataA, 16'h0000);
    idle(3);
    repeat (400) begin
      if ($urandom_range(0, 149) == 0) pulseReset();
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)));
    end
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
